// File: rtl/multi_sync_rx.sv
// rtl/multi_sync_rx.sv - multi-channel level synchronizer with edge counters and 4-phase handshake receiver
//
// Ports:
//   clk         rising-edge clock for every flop
//   rst         synchronous active-high reset
//   ena         block enable (FSM, pulses, counters hold when low)
//   async_lvl   CH asynchronous level inputs
//   lvl_sync    CH synchronized levels (last chain stage)
//   rise_pls    CH registered one-cycle rising-edge pulses
//   fall_pls    CH registered one-cycle falling-edge pulses
//   req_async   4-phase request from the external domain
//   data_async  WIDTH bundled data, stable while req_async is high
//   ack_async   registered 4-phase acknowledge
//   data_out    WIDTH captured data
//   data_valid  consumer valid
//   dst_ready   consumer ready
//   cnt_clr     clears all rising-edge counters
//   cnt_sel     counter select; indices >= CH read 0
//   cnt_out     selected 8-bit saturating rising-edge count
module multi_sync_rx #(
  parameter int WIDTH  = 8,
  parameter int CH     = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [CH-1:0]    async_lvl,
  output logic [CH-1:0]    lvl_sync,
  output logic [CH-1:0]    rise_pls,
  output logic [CH-1:0]    fall_pls,
  input  logic             req_async,
  input  logic [WIDTH-1:0] data_async,
  output logic             ack_async,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             dst_ready,
  input  logic             cnt_clr,
  input  logic [2:0]       cnt_sel,
  output logic [7:0]       cnt_out
);

  typedef enum logic [1:0] {
    S_RESYNC = 2'd0,
    S_IDLE   = 2'd1,
    S_VALID  = 2'd2,
    S_ACK    = 2'd3
  } state_e;

  // One chain per level bit plus one for req (bit CH); element 0 is the
  // first stage, element STAGES-1 the synchronized output.
  logic [STAGES-1:0][CH:0] chain_q;
  logic [CH:0]             chain_last;
  logic                    req_s;

  // Counts edges since reset until the chains hold only post-reset samples;
  // before that req_s reads 0 merely because the chain was cleared.
  logic [2:0]              fill_q;
  logic                    chain_full;

  logic [CH-1:0]           prev_q;
  logic [CH-1:0]           rise_q, rise_d;
  logic [CH-1:0]           fall_q, fall_d;
  logic [7:0]              rise_ext;
  logic [7:0]              cnt_q [8];

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        data_q, data_d;
  logic                    dv_q, dv_d;
  logic                    ack_q, ack_d;

  assign chain_last = chain_q[STAGES-1];
  assign lvl_sync   = chain_last[CH-1:0];
  assign req_s      = chain_last[CH];
  assign chain_full = (fill_q == 3'(STAGES));

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
      fill_q  <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], {req_async, async_lvl}};
      if (!chain_full) begin
        fill_q <= fill_q + 3'd1;
      end
    end
  end

  // Edge detection: prev follows lvl_sync every cycle, so re-enabling does
  // not release a stale edge that happened while disabled.
  assign rise_d   = ena ? (lvl_sync & ~prev_q) : '0;
  assign fall_d   = ena ? (~lvl_sync & prev_q) : '0;
  assign rise_ext = 8'(rise_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      prev_q <= lvl_sync;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_pls = rise_q;
  assign fall_pls = fall_q;

  // Eight counter slots so cnt_sel indexes directly; slots >= CH stay 0.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (rst || i >= CH) begin
        cnt_q[i] <= '0;
      end else if (ena) begin
        if (cnt_clr) begin
          cnt_q[i] <= '0;
        end else if (rise_ext[i] && cnt_q[i] != 8'hFF) begin
          cnt_q[i] <= cnt_q[i] + 8'd1;
        end
      end
    end
  end

  assign cnt_out = cnt_q[cnt_sel];

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dv_d    = dv_q;
    ack_d   = ack_q;
    if (ena) begin
      case (state_q)
        S_RESYNC: begin
          if (chain_full && !req_s) begin
            state_d = S_IDLE;
          end
        end
        S_IDLE: begin
          if (req_s) begin
            data_d  = data_async;
            dv_d    = 1'b1;
            state_d = S_VALID;
          end
        end
        S_VALID: begin
          // A req drop here is a sender violation; still finish via ACK.
          if (dst_ready) begin
            dv_d    = 1'b0;
            ack_d   = 1'b1;
            state_d = S_ACK;
          end
        end
        S_ACK: begin
          if (!req_s) begin
            ack_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_RESYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RESYNC;
      data_q  <= '0;
      dv_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      ack_q   <= ack_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = dv_q;
  assign ack_async  = ack_q;

endmodule

// File: tb/tb_multi_sync_rx.sv
// tb/tb_multi_sync_rx.sv - bench for multi_sync_rx across STAGES 2..4
module tb_multi_sync_rx;

  logic        clk;
  logic        rst, ena, req, rdy, clr;
  logic [7:0]  a_lvl;
  logic [15:0] a_data;
  logic [2:0]  sel;
  int          checks, failures;
  bit          chk_on;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int S = 2 + g;
    localparam int C = (g == 0) ? 4 : 8;
    localparam int W = (g == 0) ? 8 : 16;

    logic [C-1:0] lvl, rise, fall;
    logic [W-1:0] dout;
    logic         dv, ack;
    logic [7:0]   cnt;

    multi_sync_rx #(.WIDTH(W), .CH(C), .STAGES(S)) u_dut (
      .clk(clk), .rst(rst), .ena(ena),
      .async_lvl(a_lvl[C-1:0]), .lvl_sync(lvl), .rise_pls(rise), .fall_pls(fall),
      .req_async(req), .data_async(a_data[W-1:0]), .ack_async(ack),
      .data_out(dout), .data_valid(dv), .dst_ready(rdy),
      .cnt_clr(clr), .cnt_sel(sel), .cnt_out(cnt)
    );

    // Reference: a queue of raw samples (newest first, {req, levels}); the
    // synchronized view is the sample taken S edges ago, or 0 if fewer
    // than S samples were taken since reset.
    logic [8:0]  q[$];
    int          m_phase;  // 0 await req low, 1 idle, 2 offering, 3 acking
    logic [7:0]  m_lvl, m_prev, m_rise, m_fall;
    logic [7:0]  m_cnt [8];
    logic [15:0] m_data;
    logic        m_dv, m_ack;
    logic        full, req_s;
    logic [8:0]  seen;
    logic [49:0] exp_v, act_v;

    always @(posedge clk) begin
      full  = (q.size() >= S);
      seen  = full ? q[S-1] : 9'h0;
      req_s = seen[8];
      if (rst) begin
        q.delete();
        m_phase = 0;
        m_lvl = 0; m_prev = 0; m_rise = 0; m_fall = 0;
        m_data = 0; m_dv = 0; m_ack = 0;
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      end else begin
        m_rise = ena ? (m_lvl & ~m_prev) : 8'h0;
        m_fall = ena ? (~m_lvl & m_prev) : 8'h0;
        if (ena) begin
          for (int i = 0; i < 8; i++) begin
            if (clr) m_cnt[i] = 0;
            else if (m_rise[i] && m_cnt[i] != 8'd255) m_cnt[i] = m_cnt[i] + 8'd1;
          end
          case (m_phase)
            0: if (full && !req_s) m_phase = 1;
            1: if (req_s) begin m_data = 16'(a_data[W-1:0]); m_dv = 1; m_phase = 2; end
            2: if (rdy) begin m_dv = 0; m_ack = 1; m_phase = 3; end
            default: if (!req_s) begin m_ack = 0; m_phase = 1; end
          endcase
        end
        m_prev = m_lvl;
        q.push_front({req, 8'(a_lvl[C-1:0])});
        if (q.size() > S) q.pop_back();
        m_lvl = (q.size() >= S) ? q[S-1][7:0] : 8'h0;
      end
    end

    always @(negedge clk) begin
      if (chk_on) begin
        exp_v = {m_lvl, m_rise, m_fall, m_ack, m_dv, m_data,
                 (int'(sel) < C) ? m_cnt[sel] : 8'h0};
        act_v = {8'(lvl), 8'(rise), 8'(fall), ack, dv, 16'(dout), cnt};
        checks++;
        if (act_v !== exp_v) begin
          failures++;
          $display("FAIL model_cmp inst%0d t=%0t actual=%h required=%h", g, $time, act_v, exp_v);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  int          lat [3];
  logic        acc;

  initial begin
    checks = 0; failures = 0; chk_on = 0;
    rst = 1; ena = 1; req = 0; rdy = 0; clr = 0;
    a_lvl = 0; a_data = 0; sel = 0;
    tick(); chk_on = 1;
    tick(); tick();
    chk("reset_outputs", {gi[0].lvl, gi[0].rise, gi[0].fall, 7'(gi[0].ack), 8'(gi[0].dv), gi[0].dout},
        32'h0);
    chk("reset_cnt", 32'(gi[0].cnt), 32'h0);
    rst = 0;
    for (int i = 0; i < 6; i++) tick();

    // single rising edge on channel 0
    a_lvl[0] = 1'b1;
    tick();  // edge 0
    chk("lvl0_edge0", 32'(gi[0].lvl[0]), 32'h0);
    tick();  // edge 1
    chk("lvl0_edge1", 32'(gi[0].lvl[0]), 32'h1);
    chk("rise0_edge1", 32'(gi[0].rise[0]), 32'h0);
    chk("s3_lvl0_edge1", 32'(gi[1].lvl[0]), 32'h0);
    tick();  // edge 2
    chk("rise0_edge2", 32'(gi[0].rise[0]), 32'h1);
    chk("cnt0_edge2", 32'(gi[0].cnt), 32'h1);
    chk("s3_lvl0_edge2", 32'(gi[1].lvl[0]), 32'h1);
    chk("s4_lvl0_edge2", 32'(gi[2].lvl[0]), 32'h0);
    tick();  // edge 3
    chk("rise0_edge3", 32'(gi[0].rise[0]), 32'h0);
    chk("s4_lvl0_edge3", 32'(gi[2].lvl[0]), 32'h1);

    // 300 edges on channels 1 and 5: saturation and out-of-range select
    for (int i = 0; i < 600; i++) begin
      a_lvl[1] = ~a_lvl[1];
      a_lvl[5] = ~a_lvl[5];
      tick();
    end
    for (int i = 0; i < 6; i++) tick();
    sel = 3'd1; #1;
    chk("sat_s2", 32'(gi[0].cnt), 32'd255);
    chk("sat_s3", 32'(gi[1].cnt), 32'd255);
    chk("sat_s4", 32'(gi[2].cnt), 32'd255);
    sel = 3'd5; #1;
    chk("sel_ge_ch", 32'(gi[0].cnt), 32'h0);
    chk("sel5_ch8", 32'(gi[1].cnt), 32'd255);
    sel = 3'd1;
    for (int i = 0; i < 4; i++) begin
      a_lvl[1] = ~a_lvl[1];
      tick();
    end
    clr = 1; a_lvl[1] = ~a_lvl[1];
    tick();
    clr = 0;
    chk("clr_s2", 32'(gi[0].cnt), 32'h0);
    chk("clr_s3", 32'(gi[1].cnt), 32'h0);
    chk("clr_s4", 32'(gi[2].cnt), 32'h0);
    for (int i = 0; i < 6; i++) tick();

    // handshake with capture / release latency per STAGES
    req = 1; a_data = 16'h00A5; rdy = 0;
    for (int g = 0; g < 3; g++) lat[g] = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (lat[0] == 0 && gi[0].dv) lat[0] = k;
      if (lat[1] == 0 && gi[1].dv) lat[1] = k;
      if (lat[2] == 0 && gi[2].dv) lat[2] = k;
    end
    chk("cap_lat_s2", 32'(lat[0]), 32'd3);
    chk("cap_lat_s3", 32'(lat[1]), 32'd4);
    chk("cap_lat_s4", 32'(lat[2]), 32'd5);
    chk("cap_data", 32'(gi[0].dout), 32'hA5);
    for (int i = 0; i < 5; i++) tick();
    chk("hold_dv", 32'(gi[0].dv), 32'h1);
    chk("hold_noack", 32'(gi[0].ack), 32'h0);
    rdy = 1;
    tick();
    rdy = 0;
    chk("ack_set", {30'h0, gi[0].ack, gi[0].dv}, 32'h2);
    req = 0;
    for (int g = 0; g < 3; g++) lat[g] = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (lat[0] == 0 && !gi[0].ack) lat[0] = k;
      if (lat[1] == 0 && !gi[1].ack) lat[1] = k;
      if (lat[2] == 0 && !gi[2].ack) lat[2] = k;
    end
    chk("rel_lat_s2", 32'(lat[0]), 32'd3);
    chk("rel_lat_s3", 32'(lat[1]), 32'd4);
    chk("rel_lat_s4", 32'(lat[2]), 32'd5);

    // reset while in ACK with req still high
    req = 1; a_data = 16'h005A; rdy = 1;
    for (int i = 0; i < 8; i++) tick();
    chk("pre_rst_ack", 32'(gi[0].ack), 32'h1);
    rst = 1;
    tick();
    rst = 0; rdy = 0;
    chk("rst_ack_dv", {30'h0, gi[0].ack, gi[0].dv}, 32'h0);
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      acc = acc | gi[0].dv | gi[1].dv | gi[2].dv;
    end
    chk("no_dv_after_rst", 32'(acc), 32'h0);
    req = 0;
    for (int i = 0; i < 8; i++) tick();
    req = 1;
    for (int i = 0; i < 8; i++) tick();
    chk("dv_after_resync", {29'h0, gi[0].dv, gi[1].dv, gi[2].dv}, 32'h7);
    rdy = 1; tick(); rdy = 0; req = 0;
    for (int i = 0; i < 8; i++) tick();

    // enable low during VALID with ready high
    req = 1; a_data = 16'h003C;
    for (int i = 0; i < 8; i++) tick();
    ena = 0; rdy = 1; sel = 3'd2; a_lvl[2] = 1'b1;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      acc = acc | (|gi[0].rise) | (|gi[2].rise);
    end
    chk("ena0_noack", {30'h0, gi[0].ack, gi[0].dv}, 32'h1);
    chk("ena0_nopulse", 32'(acc), 32'h0);
    chk("ena0_lvl_s2", 32'(gi[0].lvl[2]), 32'h1);
    chk("ena0_lvl_s4", 32'(gi[2].lvl[2]), 32'h1);
    chk("ena0_nocnt", 32'(gi[0].cnt), 32'h0);
    ena = 1;
    tick();
    chk("ena1_ack", {29'h0, gi[0].ack, gi[1].ack, gi[2].ack}, 32'h7);
    tick();
    chk("ena1_nostale_cnt", 32'(gi[0].cnt), 32'h0);
    rdy = 0; req = 0;
    for (int i = 0; i < 8; i++) tick();

    // randomized traffic against the reference
    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(0, 399) == 0);
      ena = ($urandom_range(0, 9) != 0);
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 7) == 0) a_lvl[b] = ~a_lvl[b];
      end
      if ($urandom_range(0, 9) == 0) req = ~req;
      if (!req) a_data = 16'($urandom);
      rdy = ($urandom_range(0, 2) != 0);
      clr = ena && ($urandom_range(0, 99) == 0);
      sel = 3'($urandom_range(0, 7));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_sync_rx.md
MULTI_SYNC_RX -- requirements
Module: multi_sync_rx

Interface
REQ-001 Parameter WIDTH, default 8, handshake data width, legal range 1-16.
REQ-002 Parameter CH, default 4, number of level-synchronized channels, legal range 1-8.
REQ-003 Parameter STAGES, default 2, synchronizer flop depth, legal range 2-4.
REQ-004 clk  in  1  single clock; every flop in the block is clocked on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 ena  in  1  block enable; it is a synchronous input.
REQ-007 async_lvl  in  CH  asynchronous level inputs.
REQ-008 lvl_sync  out  CH  synchronized levels, taken from the last stage of each chain.
REQ-009 rise_pls / fall_pls  out  CH each  one-cycle rising-edge / falling-edge pulses per channel.
REQ-010 req_async  in  1  4-phase request from the external domain.
REQ-011 data_async  in  WIDTH  bundled data; the sender holds it stable while req_async is high.
REQ-012 ack_async  out  1  4-phase acknowledge; it is a registered output.
REQ-013 data_out  out  WIDTH  captured data.
REQ-014 data_valid  in  1 / dst_ready  in  1: data_valid is an output, dst_ready is an input; the pair forms a valid/ready consumer handshake.
REQ-015 cnt_clr  in  1 and cnt_sel  in  3: counter clear and channel select (index values >= CH read 0).
REQ-016 cnt_out  out  8  rising-edge count for the selected channel.

Function
REQ-017 Every async_lvl bit and req_async shall pass through its own STAGES-deep flop chain; no logic between stages.
REQ-018 The chains shall shift every cycle regardless of ena.
REQ-019 lvl_sync shall equal the last chain stage; total latency from the first sampling edge is STAGES cycles.
REQ-020 rise_pls[i] = ena & lvl_sync[i] & !prev[i]; fall_pls[i] = ena & !lvl_sync[i] & prev[i]. prev is the previous-cycle lvl_sync and updates every cycle.
REQ-021 Per-channel 8-bit counter, incrementing on rise_pls[i]: saturates at 255 with no wrap; cnt_clr clears all counters; clear has priority over a same-cycle increment.
REQ-022 cnt_out shall be combinational from cnt_sel.
REQ-023 Receiver FSM states: RESYNC, IDLE, VALID, ACK. req_s denotes the synchronized req.
REQ-024 RESYNC: go to IDLE when req_s==0.
REQ-025 IDLE: when req_s==1, capture data_async into data_out, set data_valid=1, go to VALID.
REQ-026 VALID: hold data_out and data_valid; when dst_ready==1, clear data_valid, set ack_async=1, go to ACK.
REQ-027 ACK: hold ack_async=1 until req_s==0, then clear ack_async and go to IDLE.
REQ-028 When ena==0 the FSM, data_out, data_valid, ack_async and counters shall hold their values; no pulses are issued.
REQ-029 Capture latency: data_valid rises STAGES+1 rising edges after the first edge sampling req_async high.
REQ-030 Release latency: ack_async falls STAGES+1 edges after the first edge sampling req_async low.
REQ-031 data_out shall change only on IDLE->VALID.
REQ-032 A req_async deassertion seen in VALID is a protocol violation: the FSM still waits for dst_ready, then passes through ACK, where ack drops one cycle later.

Reset
REQ-033 On rst==1 at a clock edge, all chain flops, prev, lvl_sync, rise_pls, fall_pls, counters, data_out, data_valid and ack_async shall be 0, and the FSM shall enter RESYNC.
REQ-034 rst shall override ena, cnt_clr and dst_ready.
REQ-035 A reset mid-handshake with req_async still high shall not start a new transfer until req_s has been observed 0 (RESYNC).

Verification
REQ-036 STAGES=2, async_lvl[0] 0->1 before edge 0 -> lvl_sync[0]=1 after edge 1; rise_pls[0]=1 for exactly one cycle after edge 2; cnt_out (sel 0) = 1.
REQ-037 300 rising edges on channel 1 -> cnt_out=255, no wrap. Then cnt_clr together with an edge -> cnt_out=0.
REQ-038 Handshake test: req_async=1 with data_async=8'hA5 -> data_valid=1 and data_out=8'hA5 after STAGES+1 edges. Then hold dst_ready=0 for 5 cycles -> data_valid stays 1 and ack_async stays 0. Then dst_ready=1 -> ack_async=1. Then req_async=0 -> ack_async=0 after STAGES+1 edges, FSM returns to IDLE.
REQ-039 Reset test: rst asserted in ACK with req_async=1 -> ack_async=0 and data_valid=0 on the next cycle; no data_valid appears until req_async goes 0 and then 1 again.
REQ-040 Enable test: ena=0 during VALID with dst_ready=1 -> no ack_async; edges on async_lvl produce no pulses and no counts; lvl_sync still tracks the inputs.
REQ-041 Parameter sweep: STAGES in {2,3,4}, CH=8, WIDTH=16 -> latencies scale per REQ-019, REQ-029 and REQ-030; cnt_sel values >= CH read 0.
